// File: rtl/serial_add_nand_pkg.sv
// Shared definitions for the bit-serial NAND adder: state encoding and counter sizing.
package serial_add_nand_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = S_IDLE,
    ST_SHIFT = S_SHIFT,
    ST_DONE  = S_DONE
  } state_t;

  // Bit counter must hold 0..WIDTH-1 and never collapse to zero width.
  function automatic int cnt_width(input int w);
    return (w <= 1) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_add_nand_fa_nand.sv
// One-bit full adder built from nine two-input NAND gates; purely combinational.
module fa_nand (
  input  wire a,
  input  wire b,
  input  wire cin,
  output wire s,
  output wire cout
);

  wire w_n1, w_n2, w_n3, w_n4, w_n5, w_n6, w_n7;

  // First half adder: w_n4 = a ^ b, w_n1 = ~(a & b).
  nand g1 (w_n1, a, b);
  nand g2 (w_n2, a, w_n1);
  nand g3 (w_n3, b, w_n1);
  nand g4 (w_n4, w_n2, w_n3);

  // Second half adder against carry-in; carry merges both NAND'd generate terms.
  nand g5 (w_n5, w_n4, cin);
  nand g6 (w_n6, w_n4, w_n5);
  nand g7 (w_n7, cin, w_n5);
  nand g8 (s, w_n6, w_n7);
  nand g9 (cout, w_n5, w_n1);

endmodule

// File: rtl/serial_add_nand.sv
// Bit-serial WIDTH-bit adder, LSB first, reusing one NAND full-adder cell per clock.
// States: IDLE = waiting for operands | SHIFT = one bit per clock | DONE = holding result.
module serial_add_nand
  import serial_add_nand_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int             CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_cout;
  logic             r_out_valid;
  logic             r_in_ready;

  logic             w_s;
  logic             w_c_nxt;
  logic [WIDTH-1:0] w_sum_nxt;

  fa_nand u_fa (
    .a    (r_a_sh[0]),
    .b    (r_b_sh[0]),
    .cin  (r_carry),
    .s    (w_s),
    .cout (w_c_nxt)
  );

  // New sum bit enters at the MSB; written this way so WIDTH=1 needs no special case.
  assign w_sum_nxt = WIDTH'({w_s, r_sum} >> 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_a_sh      <= '0;
      r_b_sh      <= '0;
      r_sum       <= '0;
      r_cnt       <= '0;
      r_carry     <= 1'b0;
      r_cout      <= 1'b0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_a_sh     <= a;
            r_b_sh     <= b;
            r_carry    <= 1'b0;
            r_cnt      <= '0;
            r_sum      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_sum   <= w_sum_nxt;
          r_a_sh  <= r_a_sh >> 1;
          r_b_sh  <= r_b_sh >> 1;
          r_carry <= w_c_nxt;
          r_cnt   <= r_cnt + CW'(1);
          if (r_cnt == CNT_LAST) begin
            r_cout      <= w_c_nxt;
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;

endmodule

// File: tb/tb_serial_add_nand.sv
// Directed bench for serial_add_nand at WIDTH=8, exhaustive WIDTH=4, WIDTH=1, and the fa_nand cell.
module tb_serial_add_nand;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       in_valid = 1'b0, out_ready = 1'b1;
  logic [7:0] a = '0, b = '0, sum;
  logic       in_ready, out_valid, cout;

  logic       in_valid4 = 1'b0, out_ready4 = 1'b1;
  logic [3:0] a4 = '0, b4 = '0, sum4;
  logic       in_ready4, out_valid4, cout4;

  logic       in_valid1 = 1'b0, out_ready1 = 1'b1;
  logic [0:0] a1 = '0, b1 = '0, sum1;
  logic       in_ready1, out_valid1, cout1;

  logic       fa_a = 1'b0, fa_b = 1'b0, fa_c = 1'b0;
  logic       fa_s, fa_co;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_add_nand #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout));

  serial_add_nand #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .out_valid(out_valid4), .out_ready(out_ready4),
    .sum(sum4), .cout(cout4));

  serial_add_nand #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .out_valid(out_valid1), .out_ready(out_ready1),
    .sum(sum1), .cout(cout1));

  fa_nand u_fa (.a(fa_a), .b(fa_b), .cin(fa_c), .s(fa_s), .cout(fa_co));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one WIDTH=8 operation; returns clocks from accept to out_valid and in_ready-low samples.
  task automatic op8(input logic [7:0] ta, input logic [7:0] tb_v, output int lat, output int low);
    a = ta; b = tb_v; in_valid = 1'b1;
    lat = 0; low = 0;
    tick();
    in_valid = 1'b0;
    if (!in_ready) low++;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
      if (!in_ready) low++;
    end
  endtask

  initial begin
    int lat, low, hold_ok, seen;

    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);

    // 1: basic add, consumer always ready
    op8(8'h5A, 8'h3C, lat, low);
    chk("t1_latency", lat, 8);
    chk("t1_sum", sum, 8'h96);
    chk("t1_cout", cout, 0);
    tick();
    chk("t1_in_ready_low_cycles", low, 9);
    chk("t1_back_idle", in_ready, 1);
    chk("t1_out_valid_drop", out_valid, 0);
    chk("t1_sum_kept_idle", sum, 8'h96);

    // 2: carry boundaries
    op8(8'hFF, 8'h01, lat, low);
    chk("t2a_sum", sum, 8'h00);
    chk("t2a_cout", cout, 1);
    tick();
    op8(8'hFF, 8'hFF, lat, low);
    chk("t2b_sum", sum, 8'hFE);
    chk("t2b_cout", cout, 1);
    tick();

    // 3: backpressure
    out_ready = 1'b0;
    op8(8'hC3, 8'h4E, lat, low);
    chk("t3_latency", lat, 8);
    hold_ok = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (out_valid && !in_ready && sum == 8'h11 && cout) hold_ok++;
    end
    chk("t3_held_cycles", hold_ok, 5);
    out_ready = 1'b1;
    tick();
    chk("t3_release_out_valid", out_valid, 0);
    chk("t3_release_in_ready", in_ready, 1);

    // 4: in_valid during SHIFT must be ignored
    a = 8'h21; b = 8'h13; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    a = 8'h11; b = 8'h11; in_valid = 1'b1;
    tick();
    tick();
    in_valid = 1'b0; a = '0; b = '0;
    lat = 3;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    chk("t4_latency", lat, 8);
    chk("t4_sum", sum, 8'h34);
    chk("t4_cout", cout, 0);
    tick();
    chk("t4_no_reaccept", in_ready, 1);

    // 5: reset mid-SHIFT
    a = 8'hAA; b = 8'h55; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk("t5_out_valid", out_valid, 0);
    chk("t5_sum", sum, 0);
    chk("t5_cout", cout, 0);
    chk("t5_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid) seen++;
    end
    chk("t5_no_result", seen, 0);
    chk("t5_in_ready_after", in_ready, 1);

    // 6a: exhaustive WIDTH=4
    for (int i = 0; i < 256; i++) begin
      a4 = 4'(i >> 4); b4 = 4'(i); in_valid4 = 1'b1;
      tick();
      in_valid4 = 1'b0;
      lat = 0;
      while (!out_valid4 && lat < 20) begin
        tick();
        lat++;
      end
      if (i == 0) chk("w4_latency", lat, 4);
      chk($sformatf("w4_%0h_%0h", i >> 4, i & 15), {cout4, sum4}, (i >> 4) + (i & 15));
      tick();
    end

    // 6b: WIDTH=1 edge case
    for (int i = 0; i < 4; i++) begin
      a1 = 1'(i >> 1); b1 = 1'(i); in_valid1 = 1'b1;
      tick();
      in_valid1 = 1'b0;
      lat = 0;
      while (!out_valid1 && lat < 10) begin
        tick();
        lat++;
      end
      chk("w1_latency", lat, 1);
      chk($sformatf("w1_%0d_%0d", i >> 1, i & 1), {cout1, sum1}, (i >> 1) + (i & 1));
      tick();
    end

    // 6c: full-adder cell truth table
    for (int i = 0; i < 8; i++) begin
      fa_a = i[2]; fa_b = i[1]; fa_c = i[0];
      #1;
      chk($sformatf("fa_row%0d", i), {fa_co, fa_s}, i[2] + i[1] + i[0]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
